ps2_key_fifo: RTL and testbench
===============================

# ps2_key_fifo

PS/2 keyboard receiver with a small scan-code FIFO, feeding the memory block's keyboard register. It samples the raw `keyboard_clock`/`keyboard_data` lines in the CPU clock domain and deframes 11-bit PS/2 frames. It filters out break (release) sequences and queues make codes. The memory block reads the head code through `pressed_key` and pops it with `clean_key_buffer`.

## Interface
- FIFO_DEPTH, 4, number of queued make codes; must be a power of two, 2..16
- TIMEOUT_CYCLES, 50000, CLK cycles without a PS/2 falling edge before a partial frame is abandoned
- CLK  input  1  CPU clock; everything is in this single domain
- reset  input  1  synchronous, active-high reset
- keyboard_clock  input  1  raw PS/2 clock, asynchronous
- keyboard_data  input  1  raw PS/2 data, asynchronous
- clean_key_buffer  input  1  pop request for the FIFO head, one pulse per code
- pressed_key  output  8  FIFO head make code; 8'h00 when FIFO empty
- key_valid  output  1  FIFO not empty
- frame_error  output  1  one-cycle pulse on a parity, stop-bit or timeout failure
- overflow  output  1  one-cycle pulse when a make code is dropped because the FIFO is full

## Operation
- **Input sync:** both PS/2 lines pass through 2-FF synchronizers. A third register on the clock line detects edges: `fall` = prev & ~sync.
- **Frame FSM states:**
  - IDLE: on `fall` with data=0 (start bit), go to RECV with bit_cnt=1. On `fall` with data=1, stay in IDLE with no error.
  - RECV: each `fall` samples data. Bits 1-8 shift into the data register LSB-first. Bit 9 is parity. Bit 10 is stop.
  - After bit 10, return to IDLE. The frame is valid if (^data ^ parity)==1 (odd parity) and stop==1. Otherwise pulse `frame_error`.
- **Timeout:** in RECV, a counter increments every cycle and clears on each `fall`. When it reaches TIMEOUT_CYCLES-1, go to IDLE and pulse `frame_error`. The counter is held at 0 in IDLE.
- **Byte filter:** applied to valid frames only.
  - 8'hF0: set break_pending; no push.
  - 8'hE0: no push; break_pending is unchanged.
  - Any other byte with break_pending=1: clear break_pending; no push.
  - Any other byte with break_pending=0: push the byte into the FIFO.
- **FIFO:** circular buffer with read/write pointers of log2(FIFO_DEPTH) bits plus a count of log2(FIFO_DEPTH)+1 bits. Pointers wrap modulo FIFO_DEPTH.
- **Pop:** `clean_key_buffer` while empty is ignored.
- **Push while full:** the new code is dropped, `overflow` pulses, and stored contents are unchanged.
- **Simultaneous push and pop:**
  - Non-empty FIFO: both occur and count is unchanged.
  - Full FIFO: the pop is applied first, so the push succeeds and there is no overflow.
  - Empty FIFO: only the push occurs.
- **Reset** (including mid-frame): FSM to IDLE, bit_cnt=0, timeout counter=0, break_pending=0, FIFO pointers and count to 0. Synchronizer registers reset to 1 (idle-high bus).

## Timing
- **Reset values:** pressed_key=8'h00, key_valid=0, frame_error=0, overflow=0.
- **Synchronizer latency:** a line change reaches `fall` 3 CLK edges later.
- **Push latency:** the stop bit is sampled on the edge where `fall` is high. The push happens on the following edge. `key_valid`=1 and `pressed_key`=code are visible in the cycle after the push.
- **Pop latency:** a pop on edge N makes the new head (or 8'h00 if empty) visible after edge N.
- **Output style:** `pressed_key` is combinational from the registered FIFO storage and head pointer. `key_valid` is derived from the registered count.
- **Error/overflow pulses:** `frame_error` and `overflow` are registered, high for exactly one cycle, and issued in the same cycle the push would have occurred.
- **PS/2 rate:** PS/2 clock is 10-16.7 kHz. Any CLK at or above 1 MHz is sufficient. TIMEOUT_CYCLES is sized at about 1 ms of CLK.

## Test plan
- **Single make code:** send the frame for 8'h1C (start 0, data 0,0,1,1,1,0,0,0, parity 0, stop 1) -> key_valid=1, pressed_key=8'h1C. One pop -> key_valid=0, pressed_key=8'h00.
- **Break filtering:** send 8'h1C, 8'hF0, 8'h1C -> exactly one entry (8'h1C). Then send 8'hE0, 8'h75 -> second entry 8'h75, break_pending stays 0.
- **Bad parity:** send 8'h1C with parity=1 -> frame_error pulses once, FIFO stays empty. Then send a good 8'h32 -> pressed_key=8'h32.
- **Overflow with FIFO_DEPTH=4:** push 8'h15, 8'h1D, 8'h24, 8'h2D, then 8'h2C -> overflow pulses once. Four pops return 15, 1D, 24, 2D in order, and the FIFO ends empty.
- **Simultaneous events:** with the FIFO full, assert clean_key_buffer in the exact push cycle of 8'h35 -> no overflow, count stays 4, and 8'h35 is the last code read out.
- **Timeout and reset mid-frame:** stop the PS/2 clock after 5 bits -> frame_error pulses after TIMEOUT_CYCLES, then a full 8'h1C frame is received correctly. Assert reset after 6 bits -> all outputs 0, and the next full frame 8'h1C is received correctly.

Source files
------------

// File: rtl/ps2_key_fifo_if.sv
// Bus between the PS/2 key FIFO and its surroundings: raw PS/2 lines in,
// queued make codes and status pulses out.
interface ps2_key_fifo_if;
    logic       keyboard_clock;
    logic       keyboard_data;
    logic       clean_key_buffer;
    logic [7:0] pressed_key;
    logic       key_valid;
    logic       frame_error;
    logic       overflow;

    modport master (
        output keyboard_clock,
        output keyboard_data,
        output clean_key_buffer,
        input  pressed_key,
        input  key_valid,
        input  frame_error,
        input  overflow
    );

    modport slave (
        input  keyboard_clock,
        input  keyboard_data,
        input  clean_key_buffer,
        output pressed_key,
        output key_valid,
        output frame_error,
        output overflow
    );
endinterface

// File: rtl/ps2_key_fifo.sv
// PS/2 keyboard receiver: synchronizes the raw lines, deframes 11-bit frames,
// drops break sequences and queues make codes in a small circular FIFO.
module ps2_key_fifo #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic               CLK,
    input  logic               reset,
    ps2_key_fifo_if.slave      bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [0:0] {ST_IDLE, ST_RECV} state_t;

    function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
        return (^d) ^ p;
    endfunction

    state_t             state_q, state_d;
    logic               clk_s1_q, clk_s2_q, clk_prev_q;
    logic               dat_s1_q, dat_s2_q;
    logic [3:0]         bit_cnt_q;
    logic [TMO_W-1:0]   tmo_cnt_q;
    logic [7:0]         shreg_q;
    logic               parity_q;
    logic               done_q, good_q;
    logic [7:0]         byte_q;
    logic               break_pending_q;
    logic [7:0]         mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               frame_error_q, overflow_q;

    logic fall_s, tmo_hit_s, last_bit_s;
    logic start_s, shift_en_s, par_en_s, stop_en_s, tmo_s;
    logic push_req_s, pop_req_s, full_s, push_ok_s;

    assign fall_s     = clk_prev_q & ~clk_s2_q;
    assign tmo_hit_s  = (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));
    assign last_bit_s = (bit_cnt_q >= 4'd10);

    // Two-flop synchronizers plus an edge-detect stage on the PS/2 clock; idle-high reset.
    always_ff @(posedge CLK) begin
        if (reset) begin
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            clk_prev_q <= 1'b1;
            dat_s1_q   <= 1'b1;
            dat_s2_q   <= 1'b1;
        end else begin
            clk_s1_q   <= bus.keyboard_clock;
            clk_s2_q   <= clk_s1_q;
            clk_prev_q <= clk_s2_q;
            dat_s1_q   <= bus.keyboard_data;
            dat_s2_q   <= dat_s1_q;
        end
    end

    // Frame FSM state register.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Frame FSM next state; a falling edge beats a simultaneous timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (fall_s && !dat_s2_q) begin
                    state_d = ST_RECV;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RECV: begin
                if (fall_s && last_bit_s) begin
                    state_d = ST_IDLE;
                end else if (!fall_s && tmo_hit_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RECV;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Frame FSM outputs: per-bit strobes for the datapath.
    always_comb begin
        start_s    = 1'b0;
        shift_en_s = 1'b0;
        par_en_s   = 1'b0;
        stop_en_s  = 1'b0;
        tmo_s      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                start_s = fall_s & ~dat_s2_q;
            end
            ST_RECV: begin
                if (fall_s) begin
                    if (last_bit_s) begin
                        stop_en_s = 1'b1;
                    end else if (bit_cnt_q == 4'd9) begin
                        par_en_s = 1'b1;
                    end else begin
                        shift_en_s = 1'b1;
                    end
                end else begin
                    tmo_s = tmo_hit_s;
                end
            end
            default: begin
                start_s = 1'b0;
            end
        endcase
    end

    // Deframing datapath; done_q/good_q report a finished frame one cycle after the stop bit.
    always_ff @(posedge CLK) begin
        if (reset) begin
            bit_cnt_q <= 4'd0;
            tmo_cnt_q <= '0;
            shreg_q   <= 8'h00;
            parity_q  <= 1'b0;
            done_q    <= 1'b0;
            good_q    <= 1'b0;
            byte_q    <= 8'h00;
        end else begin
            done_q <= stop_en_s | tmo_s;
            good_q <= stop_en_s & odd_parity_ok(shreg_q, parity_q) & dat_s2_q;
            if (stop_en_s) begin
                byte_q <= shreg_q;
            end
            if (start_s) begin
                bit_cnt_q <= 4'd1;
            end else if (shift_en_s || par_en_s) begin
                bit_cnt_q <= bit_cnt_q + 4'd1;
            end else if (stop_en_s || tmo_s) begin
                bit_cnt_q <= 4'd0;
            end
            if (shift_en_s) begin
                shreg_q <= {dat_s2_q, shreg_q[7:1]};
            end
            if (par_en_s) begin
                parity_q <= dat_s2_q;
            end
            if (state_q == ST_IDLE || fall_s || tmo_s) begin
                tmo_cnt_q <= '0;
            end else begin
                tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
            end
        end
    end

    assign push_req_s = done_q & good_q & (byte_q != 8'hF0) & (byte_q != 8'hE0) & ~break_pending_q;
    assign pop_req_s  = bus.clean_key_buffer & (count_q != '0);
    assign full_s     = (count_q == CNT_W'(FIFO_DEPTH));
    // Pop is applied before push, so a full FIFO popped in the same cycle still accepts the code.
    assign push_ok_s  = push_req_s & (~full_s | pop_req_s);

    // FIFO occupancy next value.
    always_comb begin
        count_d = count_q;
        case ({push_ok_s, pop_req_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Break filter, FIFO pointers and status pulses.
    always_ff @(posedge CLK) begin
        if (reset) begin
            break_pending_q <= 1'b0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            frame_error_q   <= 1'b0;
            overflow_q      <= 1'b0;
        end else begin
            frame_error_q <= done_q & ~good_q;
            overflow_q    <= push_req_s & ~push_ok_s;
            count_q       <= count_d;
            if (done_q && good_q) begin
                if (byte_q == 8'hF0) begin
                    break_pending_q <= 1'b1;
                end else if (byte_q != 8'hE0) begin
                    break_pending_q <= 1'b0;
                end
            end
            if (push_ok_s) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_req_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

    // FIFO storage; contents only matter where count says they are valid.
    always_ff @(posedge CLK) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= byte_q;
        end
    end

    assign bus.pressed_key = (count_q != '0) ? mem_q[rd_ptr_q] : 8'h00;
    assign bus.key_valid   = (count_q != '0);
    assign bus.frame_error = frame_error_q;
    assign bus.overflow    = overflow_q;
endmodule

// File: tb/tb_ps2_key_fifo.sv
// Directed bench for ps2_key_fifo: drives PS/2 frames and compares the DUT every
// cycle against a queue-based model of the make-code FIFO.
module tb_ps2_key_fifo;
    localparam int DEPTH = 4;
    localparam int TMO   = 200;

    logic clk = 1'b0;
    logic reset = 1'b1;
    ps2_key_fifo_if bus();

    ps2_key_fifo #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
        .CLK   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int   n_total = 0;
    int   n_pass  = 0;
    logic cmp_en  = 1'b0;
    logic [7:0] q[$];
    logic bp     = 1'b0;
    logic exp_fe = 1'b0;
    logic exp_ov = 1'b0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    endtask

    // Model of one completed frame: pop first, then the break filter and push.
    task automatic model_frame(input logic [7:0] b, input logic good, input logic popf);
        if (popf && q.size() != 0) q.delete(0);
        exp_fe = !good;
        exp_ov = 1'b0;
        if (good) begin
            if (b == 8'hF0) bp = 1'b1;
            else if (b == 8'hE0) bp = bp;
            else if (bp) bp = 1'b0;
            else if (q.size() < DEPTH) q.push_back(b);
            else exp_ov = 1'b1;
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("key_valid",   {7'd0, bus.key_valid},   {7'd0, q.size() != 0});
            chk("pressed_key", bus.pressed_key,         (q.size() != 0) ? q[0] : 8'h00);
            chk("frame_error", {7'd0, bus.frame_error}, {7'd0, exp_fe});
            chk("overflow",    {7'd0, bus.overflow},    {7'd0, exp_ov});
        end
    end

    task automatic ps2_frame(input logic [7:0] b, input logic bad, input int nbits,
                             input logic popf, input logic tmo);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ bad, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk) bus.keyboard_data = f[i];
            repeat (4) @(negedge clk);
            bus.keyboard_clock = 1'b0;
            if (i == 10) begin
                repeat (3) @(posedge clk);
                @(negedge clk);
                if (popf) bus.clean_key_buffer = 1'b1;
                @(posedge clk);
                #1;
                bus.clean_key_buffer = 1'b0;
                model_frame(b, !bad, popf);
                @(posedge clk);
                #1;
                exp_fe = 1'b0;
                exp_ov = 1'b0;
                repeat (4) @(negedge clk);
            end else if (tmo && i == nbits - 1) begin
                for (int k = 1; k <= TMO + 4; k++) begin
                    @(posedge clk);
                    if (k == 8) begin
                        #1 bus.keyboard_clock = 1'b1;
                    end
                end
                #1 exp_fe = 1'b1;
                @(posedge clk);
                #1 exp_fe = 1'b0;
            end else begin
                repeat (8) @(negedge clk);
            end
            bus.keyboard_clock = 1'b1;
            repeat (3) @(negedge clk);
        end
    endtask

    task automatic send(input logic [7:0] b);
        ps2_frame(b, 1'b0, 11, 1'b0, 1'b0);
    endtask

    task automatic do_pop();
        @(negedge clk) bus.clean_key_buffer = 1'b1;
        @(posedge clk);
        #1;
        bus.clean_key_buffer = 1'b0;
        if (q.size() != 0) q.delete(0);
    endtask

    task automatic lit(input string name, input logic [7:0] act_sel, input logic [7:0] exp);
        chk(name, act_sel, exp);
    endtask

    task automatic head_is(input string name, input logic [7:0] exp);
        @(posedge clk);
        #2;
        chk(name, bus.pressed_key, exp);
        chk({name, "_v"}, {7'd0, bus.key_valid}, {7'd0, exp != 8'h00});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.keyboard_clock   = 1'b1;
        bus.keyboard_data    = 1'b1;
        bus.clean_key_buffer = 1'b0;
        @(posedge clk);
        #1 cmp_en = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        lit("rst_key",   bus.pressed_key, 8'h00);
        lit("rst_valid", {7'd0, bus.key_valid}, 8'h00);
        lit("rst_fe",    {7'd0, bus.frame_error}, 8'h00);
        lit("rst_ov",    {7'd0, bus.overflow}, 8'h00);
        @(negedge clk) reset = 1'b0;

        // single make code
        send(8'h1C);
        head_is("single_head", 8'h1C);
        do_pop();
        head_is("single_empty", 8'h00);

        // break filtering and E0 prefix
        send(8'h1C); send(8'hF0); send(8'h1C);
        head_is("brk_head", 8'h1C);
        send(8'hE0); send(8'h75);
        do_pop();
        head_is("brk_second", 8'h75);
        do_pop();
        head_is("brk_empty", 8'h00);

        // bad parity, then a good frame
        ps2_frame(8'h1C, 1'b1, 11, 1'b0, 1'b0);
        head_is("par_empty", 8'h00);
        send(8'h32);
        head_is("par_good", 8'h32);
        do_pop();

        // overflow
        send(8'h15); send(8'h1D); send(8'h24); send(8'h2D); send(8'h2C);
        head_is("ov_h0", 8'h15); do_pop();
        head_is("ov_h1", 8'h1D); do_pop();
        head_is("ov_h2", 8'h24); do_pop();
        head_is("ov_h3", 8'h2D); do_pop();
        head_is("ov_end", 8'h00);

        // push and pop in the same cycle while full
        send(8'h16); send(8'h1E); send(8'h26); send(8'h25);
        ps2_frame(8'h35, 1'b0, 11, 1'b1, 1'b0);
        head_is("sim_h0", 8'h1E); do_pop();
        head_is("sim_h1", 8'h26); do_pop();
        head_is("sim_h2", 8'h25); do_pop();
        head_is("sim_h3", 8'h35); do_pop();
        head_is("sim_end", 8'h00);

        // timeout after 5 bits, then a full frame
        ps2_frame(8'h1C, 1'b0, 5, 1'b0, 1'b1);
        send(8'h1C);
        head_is("tmo_recover", 8'h1C);

        // reset mid-frame with a pending break and a queued code
        send(8'h44);
        send(8'hF0);
        ps2_frame(8'h1C, 1'b0, 6, 1'b0, 1'b0);
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1;
        q.delete();
        bp = 1'b0;
        @(negedge clk) reset = 1'b0;
        head_is("rst_mid_empty", 8'h00);
        send(8'h1C);
        head_is("rst_mid_recover", 8'h1C);
        do_pop();
        head_is("final_empty", 8'h00);

        repeat (2) @(posedge clk);
        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
